cordic_vector_sequencer: RTL and testbench
==========================================

Name: cordic_vector_sequencer

Overview:
- Iteration controller for the VECTOR-mode CORDIC datapath.
- Holds the running x/y/z state and generates the per-iteration arithmetic shifts (x_shift, y_shift) and direction bit that drive Y_Calculator and its X counterpart.
- Captures their results and accumulates the angle.
- After ITERATIONS passes, presents magnitude (x, CORDIC gain uncompensated) and angle.

Parameters:
- WIDTH, 32, datapath width, two's complement.
- ITERATIONS, 16, CORDIC iterations (1..WIDTH-1).
- CALC_LATENCY, 1, clock cycles from x_shift/y_shift/dir valid to x_next/y_next valid.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a conversion; sampled only in IDLE.
- x_in  in  WIDTH  input vector x.
- y_in  in  WIDTH  input vector y.
- y_cur  out  WIDTH  current y state, to Y_Calculator.y.
- x_cur  out  WIDTH  current x state, to X calculator.
- x_shift  out  WIDTH  x_cur >>> iter, to Y_Calculator.x_shift.
- y_shift  out  WIDTH  y_cur >>> iter, to X calculator.
- dir  out  1  y_cur[WIDTH-1]; 1 = y negative.
- iter  out  5  current iteration index.
- x_next  in  WIDTH  X calculator result.
- y_next  in  WIDTH  Y_Calculator y_out.
- busy  out  1  conversion in progress.
- done  out  1  results valid; held until next accepted start.
- magnitude  out  WIDTH  final x.
- angle  out  WIDTH  final z, radians, signed Q4.28.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs and internal x, y, z, iter, wait counter are 0.
  - Reset mid-conversion aborts it with no partial result.
- FSM states are IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE, start=1: load registers, then go to ISSUE (busy=1, done=0).
  - x_in >= 0: x=x_in, y=y_in, z=0.
  - x_in < 0 (pre-rotation): x=-x_in, y=-y_in, z=+PI if y_in >= 0, else -PI.
  - Negation of 0x80000000 saturates to 0x7FFFFFFF.
- ISSUE: x_shift, y_shift, dir are combinational from registered x, y, iter.
  - Shifts are arithmetic (sign-filling); iter=0 means no shift.
  - Clear the wait counter, then go to WAIT.
- WAIT: hold x, y, iter stable for CALC_LATENCY cycles, then go to CAPTURE.
  - CALC_LATENCY=0 skips WAIT.
- CAPTURE: x<=x_next, y<=y_next.
  - z <= z + ATAN[iter] if dir=0, else z - ATAN[iter]; 32-bit wrap.
  - If iter==ITERATIONS-1, go to DONE; otherwise iter++ and go to ISSUE.
- DONE: magnitude<=x, angle<=z, done=1, busy=0, return to IDLE.
  - done stays 1 and results stay held in IDLE until the next start is accepted.
- start while busy is ignored, with no restart.
- start asserted in the same cycle DONE is exited is accepted on the next IDLE cycle.
- Cycles per conversion = 1 + ITERATIONS*(CALC_LATENCY+2) + 1 (34+16=50 at defaults).
- x_in=y_in=0: runs the full sequence; magnitude=0, angle reflects only the ATAN accumulation (no special case).

Decomposition:
- Package cordic_pkg holds:
  - WIDTH_DEFAULT;
  - PI=0x3243F6A8 and NEG_PI;
  - ATAN_LUT[0..31] in Q4.28, atan(2^-i)*2^28 rounded (entry 0 = 0x0C90FDAA, entry 1 = 0x076B19C1);
  - state enum encoding.
- Sub-module cordic_arith_shifter, a parameterised combinational WIDTH-bit arithmetic right shift by iter, instanced twice.

Test Plan:
1. Reset mid-run: assert reset_n=0 during WAIT of iter 5 -> all outputs 0 immediately (async), state IDLE, and a later start runs normally.
2. Iteration trace: x_in=0x10000000, y_in=0, model calculators -> iter0 gives x_shift=0x10000000, y_shift=0, dir=0.
   - Capture y=0xF0000000, z=0x0C90FDAA.
   - iter1 gives dir=1, x_shift=0x08000000, y_shift=0xF8000000.
3. Quadrant pre-rotation: x_in=0xF0000000, y_in=0x00000001 -> after load x=0x10000000, y=0xFFFFFFFF, z=0x3243F6A8. Final angle is within 2^-14 rad of +PI.
4. 45 degrees: x_in=y_in=0x01000000 -> angle within 2^-14 rad of 0x0C90FDAA; magnitude is within 0.1% of 1.6468*sqrt(2)*0x01000000.
5. Handshake: start pulse while busy -> ignored, iter sequence continues. done rises exactly 50 cycles after accepted start (defaults), holds until next start, and clears the cycle after that start.
6. Saturation edge: x_in=0x80000000, y_in=0 -> loaded x=0x7FFFFFFF, z=+PI; no X propagation, done asserted.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the vectoring CORDIC sequencer.
//   WIDTH_DEFAULT : default datapath width
//   PI / NEG_PI   : +/-pi in signed Q4.28
//   atan_lut()    : atan(2^-i) in Q4.28, rounded to nearest
//   state_t       : sequencer FSM encoding
package cordic_pkg;

  localparam int          WIDTH_DEFAULT = 32;
  localparam logic [31:0] PI            = 32'h3243F6A8;
  localparam logic [31:0] NEG_PI        = 32'hCDBC0958;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Entries beyond i=28 round to zero because atan(2^-i)*2^28 < 0.5.
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  return 32'h0C90FDAA;
      5'd1:  return 32'h076B19C1;
      5'd2:  return 32'h03EB6EBF;
      5'd3:  return 32'h01FD5BAA;
      5'd4:  return 32'h00FFAADE;
      5'd5:  return 32'h007FF557;
      5'd6:  return 32'h003FFEAB;
      5'd7:  return 32'h001FFFD5;
      5'd8:  return 32'h000FFFFB;
      5'd9:  return 32'h0007FFFF;
      5'd10: return 32'h00040000;
      5'd11: return 32'h00020000;
      5'd12: return 32'h00010000;
      5'd13: return 32'h00008000;
      5'd14: return 32'h00004000;
      5'd15: return 32'h00002000;
      5'd16: return 32'h00001000;
      5'd17: return 32'h00000800;
      5'd18: return 32'h00000400;
      5'd19: return 32'h00000200;
      5'd20: return 32'h00000100;
      5'd21: return 32'h00000080;
      5'd22: return 32'h00000040;
      5'd23: return 32'h00000020;
      5'd24: return 32'h00000010;
      5'd25: return 32'h00000008;
      5'd26: return 32'h00000004;
      5'd27: return 32'h00000002;
      5'd28: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vector_sequencer_if.sv
// Bundle between the sequencer and its host / external X and Y calculators.
//   start, x_in, y_in            : conversion request
//   x_cur, y_cur, x_shift,
//   y_shift, dir, iter           : per-iteration drive to the calculators
//   x_next, y_next               : calculator results
//   busy, done, magnitude, angle : status and results
// slave = sequencer view, master = host/calculator view.
interface cordic_vector_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] x_cur;
  logic [WIDTH-1:0] y_cur;
  logic [WIDTH-1:0] x_shift;
  logic [WIDTH-1:0] y_shift;
  logic             dir;
  logic [4:0]       iter;
  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] y_next;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] magnitude;
  logic [WIDTH-1:0] angle;

  modport slave (
    input  start, x_in, y_in, x_next, y_next,
    output x_cur, y_cur, x_shift, y_shift, dir, iter,
           busy, done, magnitude, angle
  );

  modport master (
    output start, x_in, y_in, x_next, y_next,
    input  x_cur, y_cur, x_shift, y_shift, dir, iter,
           busy, done, magnitude, angle
  );
endinterface

// File: rtl/cordic_arith_shifter.sv
// Combinational arithmetic (sign-filling) right shift.
//   din   : WIDTH-bit two's complement operand
//   shamt : shift amount, 0 = pass-through
//   dout  : din >>> shamt
module cordic_arith_shifter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] dout
);
  assign dout = $signed(din) >>> shamt;
endmodule

// File: rtl/cordic_vector_sequencer.sv
// Iteration controller for a vectoring-mode CORDIC. Holds x/y/z, drives the
// shifted operands and rotation direction to external X/Y calculators,
// captures their results and accumulates the angle. After ITERATIONS passes
// it presents magnitude (gain uncompensated) and angle (Q4.28 radians).
//   clock, reset_n : rising-edge clock, async active-low reset
//   bus (slave)    : request, calculator drive/return, status and results
module cordic_vector_sequencer
  import cordic_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEFAULT,
  parameter int ITERATIONS   = 16,
  parameter int CALC_LATENCY = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  cordic_vector_sequencer_if.slave  bus
);

  localparam int         WCW       = (CALC_LATENCY > 0) ? $clog2(CALC_LATENCY + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(CALC_LATENCY - 1);
  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x, y, z;
  logic [4:0]       iter_q;
  logic [WCW-1:0]   wait_cnt;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] mag_q, ang_q;
  logic [WIDTH-1:0] x_sh, y_sh;
  logic [WIDTH-1:0] atan_w, pi_w, neg_pi_w;
  logic             dir_w;

  // -MIN has no representation; clamp it to MAX.
  function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] v);
    if (v == MIN_NEG) return MAX_POS;
    return -v;
  endfunction

  assign atan_w   = WIDTH'(signed'(atan_lut(iter_q)));
  assign pi_w     = WIDTH'(signed'(PI));
  assign neg_pi_w = WIDTH'(signed'(NEG_PI));
  assign dir_w    = y[WIDTH-1];

  cordic_arith_shifter #(.WIDTH(WIDTH)) u_x_shift (.din(x), .shamt(iter_q), .dout(x_sh));
  cordic_arith_shifter #(.WIDTH(WIDTH)) u_y_shift (.din(y), .shamt(iter_q), .dout(y_sh));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (bus.start) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = (CALC_LATENCY == 0) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = (iter_q == LAST_ITER) ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      iter_q   <= '0;
      wait_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mag_q    <= '0;
      ang_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            iter_q <= '0;
            // Left half-plane: rotate by pi so the iterations only see x >= 0.
            if (bus.x_in[WIDTH-1]) begin
              x <= neg_sat(bus.x_in);
              y <= neg_sat(bus.y_in);
              z <= bus.y_in[WIDTH-1] ? neg_pi_w : pi_w;
            end else begin
              x <= bus.x_in;
              y <= bus.y_in;
              z <= '0;
            end
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT:  wait_cnt <= wait_cnt + 1'b1;
        ST_CAPTURE: begin
          x <= bus.x_next;
          y <= bus.y_next;
          z <= dir_w ? z - atan_w : z + atan_w;
          // iter stays on the last index so the drive is stable through DONE.
          if (iter_q != LAST_ITER) iter_q <= iter_q + 5'd1;
        end
        ST_DONE: begin
          mag_q  <= x;
          ang_q  <= z;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.x_cur     = x;
  assign bus.y_cur     = y;
  assign bus.x_shift   = x_sh;
  assign bus.y_shift   = y_sh;
  assign bus.dir       = dir_w;
  assign bus.iter      = iter_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.magnitude = mag_q;
  assign bus.angle     = ang_q;

endmodule

// File: tb/tb_cordic_vector_sequencer.sv
// Self-checking bench for cordic_vector_sequencer: table of directed and
// random vectors against a behavioural CORDIC model, plus hand sequences
// for reset, iteration trace, pre-rotation, saturation and handshake.
module tb_cordic_vector_sequencer;
  import cordic_pkg::*;

  localparam int W   = 32;
  localparam int N   = 16;
  localparam int L   = 1;
  localparam int CYC = 1 + N * (L + 2) + 1;
  localparam int PI_Q = 32'h3243F6A8;
  localparam int NV  = 18;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  cordic_vector_sequencer_if #(.WIDTH(W)) bus();

  cordic_vector_sequencer #(.WIDTH(W), .ITERATIONS(N), .CALC_LATENCY(L)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  // External X/Y calculators, one-cycle registered latency.
  always @(posedge clock) begin
    bus.x_next <= bus.dir ? bus.x_cur - bus.y_shift : bus.x_cur + bus.y_shift;
    bus.y_next <= bus.dir ? bus.y_cur + bus.x_shift : bus.y_cur - bus.x_shift;
  end

  int n_chk = 0;
  int n_fail = 0;
  int atan_tab[N];

  typedef struct {
    int xi;
    int yi;
    int mag;
    int ang;
  } vec_t;
  vec_t tab[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
    longint d;
    n_chk++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic int nsat(input int v);
    return (v == int'(32'h80000000)) ? int'(32'h7FFFFFFF) : -v;
  endfunction

  // Vectoring CORDIC straight from the algorithm: drive y to zero, sum angles.
  task automatic ref_model(input int xi, input int yi, output int mag, output int ang);
    int x, y, z, xs, ys;
    if (xi < 0) begin
      x = nsat(xi); y = nsat(yi); z = (yi >= 0) ? PI_Q : -PI_Q;
    end else begin
      x = xi; y = yi; z = 0;
    end
    for (int i = 0; i < N; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (y < 0) begin x = x - ys; y = y + xs; z = z - atan_tab[i]; end
      else       begin x = x + ys; y = y - xs; z = z + atan_tab[i]; end
    end
    mag = x;
    ang = z;
  endtask

  task automatic accept(input int xi, input int yi);
    @(negedge clock);
    bus.x_in  = xi;
    bus.y_in  = yi;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // Counts rising edges after the acceptance edge until done is seen.
  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < budget) begin
      @(posedge clock); #1;
      edges++;
    end
    if (bus.done !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, edges);
    end
  endtask

  initial begin
    int e, m, a, it0;
    logic [31:0] held;
    real mexp;

    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    for (int i = 0; i < N; i++)
      atan_tab[i] = int'(longint'($atan(1.0 / (2.0 ** i)) * 268435456.0));

    tab[0] = '{xi: 0,                  yi: 0,                  mag: 0, ang: 0};
    tab[1] = '{xi: 32'h10000000,       yi: 0,                  mag: 0, ang: 0};
    tab[2] = '{xi: 32'h01000000,       yi: 32'h01000000,       mag: 0, ang: 0};
    tab[3] = '{xi: int'(32'hF0000000), yi: 1,                  mag: 0, ang: 0};
    tab[4] = '{xi: 0,                  yi: int'(32'hFF000000), mag: 0, ang: 0};
    tab[5] = '{xi: int'(32'hF8000000), yi: int'(32'hF8000000), mag: 0, ang: 0};
    for (int k = 6; k < NV; k++) begin
      tab[k].xi = int'($urandom_range(0, 32'h1FFFFFFF)) - 32'h10000000;
      tab[k].yi = int'($urandom_range(0, 32'h1FFFFFFF)) - 32'h10000000;
    end
    for (int k = 0; k < NV; k++) ref_model(tab[k].xi, tab[k].yi, tab[k].mag, tab[k].ang);

    // Reset state
    #1;
    check("rst_x_cur", bus.x_cur, 0);
    check("rst_y_cur", bus.y_cur, 0);
    check("rst_shifts", bus.x_shift | bus.y_shift, 0);
    check("rst_results", bus.magnitude | bus.angle, 0);
    check("rst_ctl", {24'd0, bus.dir, bus.busy, bus.done, bus.iter}, 0);
    @(negedge clock); reset_n = 1'b1;

    // Iteration trace
    accept(32'h10000000, 0);
    check("tr_i0_xsh", bus.x_shift, 32'h10000000);
    check("tr_i0_ysh", bus.y_shift, 0);
    check("tr_i0_dir", {31'd0, bus.dir}, 0);
    repeat (3) @(posedge clock);
    #1;
    check("tr_cap_y", bus.y_cur, 32'hF0000000);
    check("tr_cap_z", dut.z, 32'h0C90FDAA);
    check("tr_i1_iter", {27'd0, bus.iter}, 1);
    check("tr_i1_dir", {31'd0, bus.dir}, 1);
    check("tr_i1_xsh", bus.x_shift, 32'h08000000);
    check("tr_i1_ysh", bus.y_shift, 32'hF8000000);
    wait_done(200, e);

    // Quadrant pre-rotation
    accept(int'(32'hF0000000), 1);
    check("pre_x", bus.x_cur, 32'h10000000);
    check("pre_y", bus.y_cur, 32'hFFFFFFFF);
    check("pre_z", dut.z, 32'h3243F6A8);
    wait_done(200, e);
    check_tol("pre_angle_pi", longint'($signed(bus.angle)), PI_Q, 16384);

    // 45 degrees
    accept(32'h01000000, 32'h01000000);
    wait_done(200, e);
    check_tol("d45_angle", longint'($signed(bus.angle)), 32'h0C90FDAA, 16384);
    mexp = 1.6468 * $sqrt(2.0) * 16777216.0;
    check_tol("d45_mag", longint'(bus.magnitude), longint'(mexp), longint'(mexp * 0.001));

    // Saturating pre-rotation
    accept(int'(32'h80000000), 0);
    check("sat_x", bus.x_cur, 32'h7FFFFFFF);
    check("sat_y", bus.y_cur, 0);
    check("sat_z", dut.z, 32'h3243F6A8);
    wait_done(200, e);
    check("sat_known", {31'd0, $isunknown({bus.magnitude, bus.angle})}, 0);
    ref_model(int'(32'h80000000), 0, m, a);
    check("sat_mag", bus.magnitude, m);

    // Handshake: start while busy is ignored; latency; done hold/clear
    accept(32'h05000000, 32'h03000000);
    check("hs_busy", {31'd0, bus.busy}, 1);
    check("hs_done_clr", {31'd0, bus.done}, 0);
    repeat (8) @(posedge clock);
    #1; it0 = int'(bus.iter);
    @(negedge clock); bus.start = 1'b1;
    @(posedge clock); #1; bus.start = 1'b0;
    check("hs_no_restart", {27'd0, bus.iter} >= it0 ? 32'd1 : 32'd0, 1);
    wait_done(200, e);
    check("hs_latency", 32'(e + 10), CYC);
    held = bus.magnitude;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("hs_done_hold", {31'd0, bus.done}, 1);
      check("hs_mag_hold", bus.magnitude, held);
    end
    accept(32'h00100000, 0);
    check("hs_done_clr2", {31'd0, bus.done}, 0);
    wait_done(200, e);

    // Start held while leaving DONE is taken on the following IDLE cycle
    accept(32'h02000000, int'(32'hFF000000));
    e = 0;
    while (dut.state != ST_DONE && e < 200) begin @(posedge clock); #1; e++; end
    check("dx_reach", 32'(dut.state), 32'(ST_DONE));
    bus.start = 1'b1;
    @(posedge clock); #1;
    check("dx_idle_done", {30'd0, bus.busy, bus.done}, 32'd1);
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("dx_accepted", {30'd0, bus.busy, bus.done}, 32'd2);
    wait_done(200, e);

    // Reset during WAIT of iteration 5
    accept(32'h07000000, 32'h02000000);
    e = 0;
    while (!(bus.iter == 5 && dut.state == ST_WAIT) && e < 200) begin @(posedge clock); #1; e++; end
    check("mr_reach", 32'(dut.state), 32'(ST_WAIT));
    reset_n = 1'b0;
    #1;
    check("mr_state", 32'(dut.state), 32'(ST_IDLE));
    check("mr_xy", bus.x_cur | bus.y_cur | bus.x_shift | bus.y_shift, 0);
    check("mr_results", bus.magnitude | bus.angle, 0);
    check("mr_ctl", {24'd0, bus.dir, bus.busy, bus.done, bus.iter}, 0);
    @(negedge clock); reset_n = 1'b1;

    // Table: directed plus random vectors against the model
    for (int k = 0; k < NV; k++) begin
      accept(tab[k].xi, tab[k].yi);
      wait_done(200, e);
      check($sformatf("tab%0d_mag", k), bus.magnitude, tab[k].mag);
      check($sformatf("tab%0d_ang", k), bus.angle, tab[k].ang);
      check($sformatf("tab%0d_lat", k), 32'(e + 1), CYC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
